// File: rtl/match_ctrl.sv
// Rally/match sequencer: parks, releases and freezes the ball, awards points,
// picks the next server and detects end of game using vsync-derived frame ticks.
module match_ctrl #(
   parameter int unsigned NET_X        = 512,
   parameter int unsigned WIN_SCORE    = 15,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned POINT_FRAMES = 90
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vs,
   input  logic        start,
   input  logic        gnd_col,
   input  logic        ovr_touch,
   input  logic        last_touch,
   input  logic [11:0] ball_xpos,
   output logic        ball_run,
   output logic        ball_load,
   output logic        serve_side,
   output logic [4:0]  score_p1,
   output logic [4:0]  score_p2,
   output logic        endgame,
   output logic        winner,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SERVE    = 3'd1,
      S_RALLY    = 3'd2,
      S_POINT    = 3'd3,
      S_GAMEOVER = 3'd4
   } state_t;

   state_t      r_state, w_state;
   logic        r_vs_q, r_start_q;
   logic [6:0]  r_cnt, w_cnt;
   logic [4:0]  r_score_p1, w_score_p1;
   logic [4:0]  r_score_p2, w_score_p2;
   logic        r_serve_side, w_serve_side;
   logic        r_winner, w_winner;
   logic        r_ball_run, w_ball_run;
   logic        r_ball_load, w_ball_load;
   logic        r_endgame, w_endgame;

   logic        w_frame_tick;
   logic        w_start_rise;
   logic        w_lose_p1;
   logic        w_p1_lost;

   assign w_frame_tick = vs & ~r_vs_q;
   assign w_start_rise = start & ~r_start_q;

   // Ground contact decides by court half and takes priority over the touch count.
   assign w_lose_p1 = (ball_xpos < 12'(NET_X));
   assign w_p1_lost = gnd_col ? w_lose_p1 : ~last_touch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_vs_q       <= 1'b0;
         r_start_q    <= 1'b0;
         r_cnt        <= '0;
         r_score_p1   <= '0;
         r_score_p2   <= '0;
         r_serve_side <= 1'b0;
         r_winner     <= 1'b0;
         r_ball_run   <= 1'b0;
         r_ball_load  <= 1'b0;
         r_endgame    <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_vs_q       <= vs;
         r_start_q    <= start;
         r_cnt        <= w_cnt;
         r_score_p1   <= w_score_p1;
         r_score_p2   <= w_score_p2;
         r_serve_side <= w_serve_side;
         r_winner     <= w_winner;
         r_ball_run   <= w_ball_run;
         r_ball_load  <= w_ball_load;
         r_endgame    <= w_endgame;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_score_p1   = r_score_p1;
      w_score_p2   = r_score_p2;
      w_serve_side = r_serve_side;
      w_winner     = r_winner;
      w_ball_load  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_start_rise) begin
               w_score_p1   = '0;
               w_score_p2   = '0;
               w_serve_side = 1'b0;
               w_ball_load  = 1'b1;
               w_cnt        = '0;
               w_state      = S_SERVE;
            end
         end

         S_SERVE: begin
            if (w_frame_tick) begin
               if (r_cnt == 7'(SERVE_FRAMES - 1)) begin
                  w_cnt   = '0;
                  w_state = S_RALLY;
               end else begin
                  w_cnt = r_cnt + 7'd1;
               end
            end
         end

         S_RALLY: begin
            if (gnd_col || ovr_touch) begin
               if (w_p1_lost) begin
                  w_score_p2   = (r_score_p2 == 5'd31) ? r_score_p2 : r_score_p2 + 5'd1;
                  w_serve_side = 1'b1;
               end else begin
                  w_score_p1   = (r_score_p1 == 5'd31) ? r_score_p1 : r_score_p1 + 5'd1;
                  w_serve_side = 1'b0;
               end
               w_cnt   = '0;
               w_state = S_POINT;
            end
         end

         S_POINT: begin
            if (w_frame_tick) begin
               if (r_cnt == 7'(POINT_FRAMES - 1)) begin
                  w_cnt = '0;
                  if (r_score_p1 == 5'(WIN_SCORE)) begin
                     w_winner = 1'b0;
                     w_state  = S_GAMEOVER;
                  end else if (r_score_p2 == 5'(WIN_SCORE)) begin
                     w_winner = 1'b1;
                     w_state  = S_GAMEOVER;
                  end else begin
                     w_ball_load = 1'b1;
                     w_state     = S_SERVE;
                  end
               end else begin
                  w_cnt = r_cnt + 7'd1;
               end
            end
         end

         S_GAMEOVER: begin
            if (w_start_rise)
               w_state = S_IDLE;
         end

         default: w_state = S_IDLE;
      endcase

      // Status outputs are registered from the next state so they align with it.
      w_ball_run = (w_state == S_RALLY);
      w_endgame  = (w_state == S_GAMEOVER);
   end

   assign ball_run   = r_ball_run;
   assign ball_load  = r_ball_load;
   assign serve_side = r_serve_side;
   assign score_p1   = r_score_p1;
   assign score_p2   = r_score_p2;
   assign endgame    = r_endgame;
   assign winner     = r_winner;
   assign state      = r_state;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed self-checking bench for match_ctrl: serve/rally/point flow,
// loser rules, end of game and asynchronous reset mid-rally.
module tb_match_ctrl;

   localparam int unsigned SF = 60;
   localparam int unsigned PF = 90;

   logic        clk = 1'b0;
   logic        rst;
   logic        vs, start, gnd_col, ovr_touch, last_touch;
   logic [11:0] ball_xpos;
   logic        ball_run, ball_load, serve_side, endgame, winner;
   logic [4:0]  score_p1, score_p2;
   logic [2:0]  state;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   match_ctrl #(
      .NET_X(512),
      .WIN_SCORE(15),
      .SERVE_FRAMES(SF),
      .POINT_FRAMES(PF)
   ) dut (
      .clk(clk), .rst(rst), .vs(vs), .start(start), .gnd_col(gnd_col),
      .ovr_touch(ovr_touch), .last_touch(last_touch), .ball_xpos(ball_xpos),
      .ball_run(ball_run), .ball_load(ball_load), .serve_side(serve_side),
      .score_p1(score_p1), .score_p2(score_p2), .endgame(endgame),
      .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         vs = 1'b1; tick();
         vs = 1'b0; tick();
      end
   endtask

   task automatic serve_to_rally;
      frames(SF - 1);
      chk("serve_hold", 32'(state), 1);
      vs = 1'b1; tick();
      chk("rally_state", 32'(state), 2);
      chk("rally_run", 32'(ball_run), 1);
      vs = 1'b0; tick();
   endtask

   task automatic point_to_serve;
      frames(PF - 1);
      chk("point_hold", 32'(state), 3);
      vs = 1'b1; tick();
      chk("reserve_state", 32'(state), 1);
      chk("reserve_load", 32'(ball_load), 1);
      vs = 1'b0; tick();
      chk("reserve_load_end", 32'(ball_load), 0);
   endtask

   task automatic hit(input logic [11:0] x, input logic g, input logic o, input logic lt);
      ball_xpos = x; gnd_col = g; ovr_touch = o; last_touch = lt;
      tick();
      gnd_col = 1'b0; ovr_touch = 1'b0;
   endtask

   task automatic start_pulse;
      start = 1'b1; tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0; vs = 1'b0; start = 1'b0; gnd_col = 1'b0;
      ovr_touch = 1'b0; last_touch = 1'b0; ball_xpos = '0;
      tick(); tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_scores", 32'({score_p1, score_p2}), 0);
      chk("rst_run", 32'(ball_run), 0);
      chk("rst_endgame", 32'(endgame), 0);
      rst = 1'b1; tick();

      start_pulse();
      chk("start_state", 32'(state), 1);
      chk("start_load", 32'(ball_load), 1);
      chk("start_side", 32'(serve_side), 0);
      chk("start_run", 32'(ball_run), 0);
      tick();
      chk("start_load_end", 32'(ball_load), 0);
      serve_to_rally();

      hit(12'd300, 1'b1, 1'b0, 1'b0);
      chk("gnd_p1half_p2", 32'(score_p2), 1);
      chk("gnd_p1half_p1", 32'(score_p1), 0);
      chk("gnd_p1half_side", 32'(serve_side), 1);
      chk("gnd_p1half_state", 32'(state), 3);
      chk("point_run", 32'(ball_run), 0);
      hit(12'd300, 1'b1, 1'b0, 1'b0);
      chk("point_ignore_gnd", 32'(score_p2), 1);
      point_to_serve();
      chk("serve_side_held", 32'(serve_side), 1);
      serve_to_rally();

      hit(12'd700, 1'b1, 1'b1, 1'b0);
      chk("gnd_wins_p1", 32'(score_p1), 1);
      chk("gnd_wins_p2", 32'(score_p2), 1);
      chk("gnd_wins_side", 32'(serve_side), 0);
      point_to_serve();
      serve_to_rally();

      hit(12'd0, 1'b0, 1'b1, 1'b1);
      chk("ovr_p1", 32'(score_p1), 2);
      chk("ovr_p2", 32'(score_p2), 1);
      chk("ovr_side", 32'(serve_side), 0);

      for (int i = 0; i < 12; i++) begin
         point_to_serve();
         serve_to_rally();
         hit(12'd700, 1'b1, 1'b0, 1'b0);
      end
      chk("p1_at_14", 32'(score_p1), 14);
      point_to_serve();
      serve_to_rally();
      hit(12'd700, 1'b1, 1'b0, 1'b0);
      chk("p1_at_15", 32'(score_p1), 15);
      frames(PF - 1);
      chk("win_point_hold", 32'(state), 3);
      vs = 1'b1; tick();
      chk("go_state", 32'(state), 4);
      chk("go_endgame", 32'(endgame), 1);
      chk("go_winner", 32'(winner), 0);
      chk("go_load", 32'(ball_load), 0);
      chk("go_scores", 32'({score_p1, score_p2}), 32'({5'd15, 5'd1}));
      vs = 1'b0; tick();
      hit(12'd300, 1'b1, 1'b0, 1'b0);
      chk("go_ignore_gnd", 32'({score_p1, score_p2}), 32'({5'd15, 5'd1}));
      chk("go_ignore_state", 32'(state), 4);

      start_pulse();
      chk("go_to_idle", 32'(state), 0);
      chk("go_endgame_drop", 32'(endgame), 0);
      chk("idle_scores_held", 32'(score_p1), 15);
      tick();
      start_pulse();
      chk("restart_state", 32'(state), 1);
      chk("restart_scores", 32'({score_p1, score_p2}), 0);
      tick();

      for (int i = 0; i < 5; i++) begin
         serve_to_rally();
         hit((i % 2 == 0) ? 12'd700 : 12'd300, 1'b1, 1'b0, 1'b0);
         point_to_serve();
      end
      chk("pre_rst_scores", 32'({score_p1, score_p2}), 32'({5'd3, 5'd2}));
      serve_to_rally();
      rst = 1'b0; #1;
      chk("arst_state", 32'(state), 0);
      chk("arst_scores", 32'({score_p1, score_p2}), 0);
      chk("arst_run", 32'(ball_run), 0);
      chk("arst_load", 32'(ball_load), 0);
      tick();
      rst = 1'b1; tick();
      chk("arst_idle_stays", 32'(state), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
- Rally/match sequencer for the volleyball game, in the 65 MHz pixel-clock domain between the judge/collision logic and ball_pos_ctrl.
- Decides when the ball is parked for a serve, released, or frozen after a point.
- Awards points, chooses the next server and detects end of game.
- Frame timing comes from the vertical sync pulse; no other time base is used.

Parameters:
- NET_X, 512: ball x coordinate of the net; ball_xpos < NET_X is player 1's half.
- WIN_SCORE, 15: score that ends the game (1..31).
- SERVE_FRAMES, 60: frames the ball stays parked before release.
- POINT_FRAMES, 90: frames the ball stays frozen after a point.

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  asynchronous, active-low reset
- vs  in  1  vertical sync; rising edge = frame tick
- start  in  1  mouse left button (level); rising edge = start/acknowledge
- gnd_col  in  1  one-cycle pulse: ball touched the ground
- ovr_touch  in  1  one-cycle pulse: fourth touch by one side
- last_touch  in  1  side that touched the ball last (0 = P1, 1 = P2)
- ball_xpos  in  12  current ball x position
- ball_run  out  1  1 = ball physics enabled
- ball_load  out  1  one-cycle pulse: park ball above the server
- serve_side  out  1  0 = P1 serves, 1 = P2 serves
- score_p1  out  5  player 1 score
- score_p2  out  5  player 2 score
- endgame  out  1  high while in GAMEOVER
- winner  out  1  0 = P1 won, 1 = P2 won; valid when endgame = 1
- state  out  3  IDLE = 0, SERVE = 1, RALLY = 2, POINT = 3, GAMEOVER = 4

Behaviour:
- Reset state (rst = 0, asynchronous) for all registers:
  - state = IDLE; scores = 0; serve_side = 0; winner = 0.
  - ball_run = 0; ball_load = 0; endgame = 0; frame counter = 0.
  - Edge-detect registers for vs and start = 0.
  - A reset mid-rally returns to IDLE immediately.
- Edge detection:
  - frame_tick = vs & ~vs_q.
  - start_rise = start & ~start_q.
  - The q registers update every clk.
- All outputs are registered; each transition takes effect on the clock edge after its condition.
- FSM:
  - IDLE: ball_run = 0. On start_rise: clear both scores, serve_side = 0, pulse ball_load, counter = 0, go to SERVE.
  - SERVE: ball_run = 0. Counter increments on frame_tick. When counter = SERVE_FRAMES-1 and frame_tick: go to RALLY, counter = 0.
  - RALLY: ball_run = 1.
    - gnd_col: loser = (ball_xpos < NET_X) ? P1 : P2.
    - ovr_touch alone: loser = last_touch.
    - gnd_col and ovr_touch in the same cycle: gnd_col rule wins.
    - On either event: the other player's score += 1, serve_side = scorer, counter = 0, go to POINT.
  - POINT: ball_run = 0 (ball frozen in place).
    - gnd_col and ovr_touch are ignored.
    - After POINT_FRAMES frame ticks:
      - If either score = WIN_SCORE: winner = that player, go to GAMEOVER.
      - Otherwise pulse ball_load and go to SERVE.
  - GAMEOVER: endgame = 1, ball_run = 0, scores held. On start_rise: go to IDLE; endgame drops on the same edge.
- start_rise is ignored in SERVE, RALLY and POINT.
- Score increment saturates at 31. WIN_SCORE is reached first in normal play.
- Frame counter is 7 bits. SERVE_FRAMES and POINT_FRAMES must be ≤ 127.
- ball_load is high for exactly one clk per SERVE entry. serve_side is stable for that whole clk.

Test Plan:
- Reset held low mid-RALLY with score 3:2 → next sample: state = 0, scores 0:0, ball_run = 0, ball_load = 0.
- IDLE, start pulse → one ball_load pulse, serve_side = 0, state = 1. After 60 vs rising edges → state = 2, ball_run = 1 on the following clk.
- RALLY, ball_xpos = 300, gnd_col pulse → score_p2 = 1, serve_side = 1, state = 3. After 90 frames → ball_load pulse, state = 1.
- RALLY, ball_xpos = 700, gnd_col and ovr_touch together with last_touch = 0 → score_p1 += 1 (gnd rule), score_p2 unchanged.
- RALLY, ovr_touch with last_touch = 1 → score_p1 += 1, serve_side = 0.
- Score P1 = 14, P1 scores → after POINT delay: state = 4, endgame = 1, winner = 0, scores 15:x held. Extra gnd_col pulses have no effect. start pulse → state = 0. Next start pulse → scores 0:0.
